// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver state codes, default word width
// and a clog2 helper used to size the bit counter.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Receiver states kept as plain constants so older blocks can share the encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t SHIFT    = 2'd1;
    localparam state_t WAIT_LOW = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result++;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Bus between the serial receiver (slave) and the block feeding it bits and
// consuming its words (master).
interface serial_receiver_if import serial_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();

    logic             Din;
    logic             DinValid;
    logic             BitEn;
    logic             DataAck;
    logic             ClrErr;
    logic [WIDTH-1:0] DataOut;
    logic             DataValid;
    logic             RxBusy;
    logic             FrameErr;
    logic             Overrun;

    modport master (
        output Din, DinValid, BitEn, DataAck, ClrErr,
        input  DataOut, DataValid, RxBusy, FrameErr, Overrun
    );

    modport slave (
        input  Din, DinValid, BitEn, DataAck, ClrErr,
        output DataOut, DataValid, RxBusy, FrameErr, Overrun
    );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
module bit_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Deserializer for the serial transmitter's MSB-first stream, with valid/ack output
// and sticky FrameErr/Overrun flags. Define SERIAL_RX_SYNC_EN to synchronize Din/DinValid.
module serial_receiver import serial_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input logic         Clk,
    input logic         Reset,
    serial_receiver_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic             dinS;
    logic             dinValidS;
    state_t           state;
    state_t           stateNext;
    logic [WIDTH-2:0] shiftReg;
    logic [WIDTH-2:0] shiftNext;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             complete;
    logic             frameErrSet;
    logic             overrunSet;

`ifdef SERIAL_RX_SYNC_EN
    bit_sync u_dinSync      (.Clk(Clk), .Reset(Reset), .D(bus.Din),      .Q(dinS));
    bit_sync u_dinValidSync (.Clk(Clk), .Reset(Reset), .D(bus.DinValid), .Q(dinValidS));
`else
    assign dinS      = bus.Din;
    assign dinValidS = bus.DinValid;
`endif

    // The top shift bit is never stored: the completed word is the held bits plus the live bit
    always_comb begin
        stateNext   = state;
        shiftNext   = shiftReg;
        cntNext     = cnt;
        complete    = 1'b0;
        frameErrSet = 1'b0;
        word        = {shiftReg, dinS};
        case (state)
            IDLE: begin
                if (bus.BitEn && dinValidS) begin
                    shiftNext = {{(WIDTH-2){1'b0}}, dinS};
                    cntNext   = CNT_W'(1);
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (!dinValidS) begin
                    frameErrSet = 1'b1;
                    shiftNext   = '0;
                    cntNext     = '0;
                    stateNext   = IDLE;
                end else if (bus.BitEn) begin
                    shiftNext = word[WIDTH-2:0];
                    if (cnt == LAST_IDX) begin
                        complete  = 1'b1;
                        cntNext   = '0;
                        stateNext = WAIT_LOW;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (!dinValidS) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        overrunSet = complete && bus.DataValid && !bus.DataAck;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            shiftReg      <= '0;
            cnt           <= '0;
            bus.DataOut   <= '0;
            bus.DataValid <= 1'b0;
            bus.RxBusy    <= 1'b0;
            bus.FrameErr  <= 1'b0;
            bus.Overrun   <= 1'b0;
        end else begin
            state      <= stateNext;
            shiftReg   <= shiftNext;
            cnt        <= cntNext;
            bus.RxBusy <= (stateNext != IDLE);
            // An ack on the completion edge frees the slot for the new word
            if (complete && (!bus.DataValid || bus.DataAck)) begin
                bus.DataOut   <= word;
                bus.DataValid <= 1'b1;
            end else if (!complete && bus.DataValid && bus.DataAck) begin
                bus.DataValid <= 1'b0;
            end
            bus.FrameErr <= frameErrSet || (bus.FrameErr && !bus.ClrErr);
            bus.Overrun  <= overrunSet  || (bus.Overrun  && !bus.ClrErr);
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed plus randomized bench for serial_receiver against a word-level model.
// With SERIAL_RX_SYNC_EN defined the BitEn strobe is placed two cycles later in each bit.
module tb_serial_receiver;
    import serial_pkg::*;

    localparam int WIDTH      = DEFAULT_WIDTH;
    localparam int BIT_CYCLES = 4;
`ifdef SERIAL_RX_SYNC_EN
    localparam int BEN_SLOT = 3;
`else
    localparam int BEN_SLOT = 1;
`endif

    logic Clk;
    logic Reset;
    int   evalCount;
    int   failCount;

    logic [WIDTH-1:0] expData;
    logic             expValid;
    logic             expOverrun;
    logic             expFrameErr;

    serial_receiver_if #(.WIDTH(WIDTH)) bus ();

    serial_receiver #(.WIDTH(WIDTH)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        evalCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Word-level model of a completed frame
    task automatic completeWord(input logic [WIDTH-1:0] w, input bit ack);
        if (!expValid || ack) begin
            expData  = w;
            expValid = 1'b1;
        end else begin
            expOverrun = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".DataOut"},   bus.DataOut,   expData);
        checkOutput({tag, ".DataValid"}, 32'(bus.DataValid), 32'(expValid));
        checkOutput({tag, ".Overrun"},   32'(bus.Overrun),   32'(expOverrun));
        checkOutput({tag, ".FrameErr"},  32'(bus.FrameErr),  32'(expFrameErr));
    endtask

    // Sends the first nBits of w MSB first, then tailBits extra strobes with DinValid held
    task automatic applyStimulus(input logic [WIDTH-1:0] w, input int nBits, input bit ackOnLast, input int tailBits);
        for (int b = 0; b < nBits; b++) begin
            bus.Din      = w[WIDTH-1-b];
            bus.DinValid = 1'b1;
            for (int c = 0; c < BIT_CYCLES; c++) begin
                bus.BitEn   = (c == BEN_SLOT);
                bus.DataAck = ackOnLast && (b == WIDTH-1) && (c == BEN_SLOT);
                if (b == WIDTH-1 && c == BEN_SLOT)
                    checkOutput("validBeforeLast", 32'(bus.DataValid), 32'(expValid));
                tick();
                if (b == 0 && c == BEN_SLOT)
                    checkOutput("busyAfterFirst", 32'(bus.RxBusy), 32'd1);
                if (b == WIDTH-1 && c == BEN_SLOT) begin
                    completeWord(w, ackOnLast);
                    checkAll("complete");
                end
            end
        end
        bus.BitEn   = 1'b0;
        bus.DataAck = 1'b0;
        for (int t = 0; t < tailBits; t++) begin
            bus.Din = 1'($urandom);
            for (int c = 0; c < BIT_CYCLES; c++) begin
                bus.BitEn = (c == BEN_SLOT);
                tick();
            end
        end
        bus.BitEn = 1'b0;
    endtask

    task automatic endFrame();
        bus.DinValid = 1'b0;
        bus.Din      = 1'b0;
        repeat (6) tick();
        checkOutput("busyIdle", 32'(bus.RxBusy), 32'd0);
    endtask

    task automatic pulseAck();
        bus.DataAck = 1'b1;
        tick();
        bus.DataAck = 1'b0;
        expValid = 1'b0;
        checkAll("ack");
    endtask

    task automatic pulseClr();
        bus.ClrErr = 1'b1;
        tick();
        bus.ClrErr = 1'b0;
        expOverrun  = 1'b0;
        expFrameErr = 1'b0;
        checkAll("clr");
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        bit               ackFirst;
        bit               ackLast;

        evalCount    = 0;
        failCount    = 0;
        expData      = '0;
        expValid     = 1'b0;
        expOverrun   = 1'b0;
        expFrameErr  = 1'b0;
        Reset        = 1'b0;
        bus.Din      = 1'b0;
        bus.DinValid = 1'b0;
        bus.BitEn    = 1'b0;
        bus.DataAck  = 1'b0;
        bus.ClrErr   = 1'b0;

        repeat (2) tick();
        checkAll("reset");
        checkOutput("reset.RxBusy", 32'(bus.RxBusy), 32'd0);
        Reset = 1'b1;
        tick();

        // Nominal frame
        applyStimulus(32'hA5C3_0F81, WIDTH, 1'b0, 0);
        endFrame();

        // No ack: second word overruns and is dropped
        applyStimulus(32'h1234_5678, WIDTH, 1'b0, 0);
        endFrame();
        pulseClr();
        pulseAck();
        applyStimulus(32'h1234_5678, WIDTH, 1'b0, 0);
        endFrame();

        // Ack on the completion edge
        applyStimulus(32'hDEAD_BEEF, WIDTH, 1'b1, 0);
        endFrame();

        // DinValid drops after 17 bits
        applyStimulus($urandom, 17, 1'b0, 0);
        bus.DinValid = 1'b0;
        repeat (6) tick();
        expFrameErr = 1'b1;
        checkAll("frameErr");
        checkOutput("frameErr.RxBusy", 32'(bus.RxBusy), 32'd0);
        pulseAck();
        applyStimulus(32'hFFFF_0000, WIDTH, 1'b0, 0);
        endFrame();
        pulseClr();

        // Asynchronous reset in the middle of a frame
        applyStimulus($urandom, 10, 1'b0, 0);
        #2 Reset = 1'b0;
        #1;
        expData     = '0;
        expValid    = 1'b0;
        expOverrun  = 1'b0;
        expFrameErr = 1'b0;
        checkAll("midReset");
        checkOutput("midReset.RxBusy", 32'(bus.RxBusy), 32'd0);
        bus.DinValid = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        applyStimulus(32'h0000_0001, WIDTH, 1'b0, 0);
        endFrame();

        // Busy tail: extra strobes after the word must not start another frame
        pulseAck();
        applyStimulus(32'h5A5A_C3C3, WIDTH, 1'b0, 3);
        checkOutput("tail.RxBusy", 32'(bus.RxBusy), 32'd1);
        checkAll("tail");
        endFrame();
        checkAll("tailEnd");

        // Randomized frames with random ack behaviour
        for (int i = 0; i < 10; i++) begin
            w        = $urandom;
            ackFirst = 1'($urandom_range(0, 1));
            ackLast  = 1'($urandom_range(0, 1));
            if (ackFirst) pulseAck();
            applyStimulus(w, WIDTH, ackLast, $urandom_range(0, 2));
            endFrame();
            if (expOverrun) pulseClr();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Deserializer directly downstream of the serial transmitter; rebuilds WIDTH-bit words from its single-bit Dout stream.
- The transmitter sends the word MSB first, one bit per bit period, and frames the word with its busy flag.
- The receiver shifts bits in on a bit-period strobe and presents each word on a valid/ack register interface to the consumer.
- Flags framing errors and overruns.

Parameters:
- WIDTH, 32, word length in bits; must match the transmitter.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Din  input  1  serial data, driven by the transmitter's Dout.
- DinValid  input  1  frame qualifier, driven by the transmitter's TxBusy; high for the whole frame.
- BitEn  input  1  one-Clk-cycle strobe per bit period, aligned to the centre of each bit.
- DataAck  input  1  consumer has taken DataOut.
- ClrErr  input  1  clears the sticky error flags.
- DataOut  output  WIDTH  last completed word.
- DataValid  output  1  DataOut holds an unconsumed word.
- RxBusy  output  1  frame in progress (state != IDLE).
- FrameErr  output  1  sticky flag: DinValid dropped mid-frame.
- Overrun  output  1  sticky flag: a word completed while DataValid=1 and DataAck=0.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE; shift register and bit counter = 0.
  - DataOut=0, DataValid=0, RxBusy=0, FrameErr=0, Overrun=0.
- States: IDLE, SHIFT, WAIT_LOW.
- IDLE:
  - On an edge with BitEn=1 and DinValid=1: shift<={WIDTH-1 zeros, Din}, cnt<=1, go to SHIFT.
  - Otherwise remain in IDLE. Din is ignored while DinValid=0.
- SHIFT:
  - On an edge with BitEn=1 and DinValid=1: shift<={shift[WIDTH-2:0],Din}, cnt<=cnt+1.
  - When that edge captures the WIDTH-th bit (cnt==WIDTH-1 before the edge): complete the word, cnt<=0, go to WAIT_LOW.
  - On any edge with DinValid=0 while cnt<WIDTH: FrameErr<=1, discard the partial word, cnt<=0, go to IDLE. This check applies whether or not BitEn is high.
- WAIT_LOW:
  - Remain until DinValid=0, then go to IDLE.
  - Prevents the transmitter's post-frame busy tail from starting a false frame.
  - Extra BitEn pulses in this state are ignored.
- Word completion happens on the same edge that captures the last bit:
  - If DataValid=0, or DataAck=1 on that edge: DataOut<=new word, DataValid<=1.
  - Otherwise: Overrun<=1, DataOut and DataValid unchanged, new word dropped.
- Bit order:
  - The first received bit lands in DataOut[WIDTH-1]; the last lands in DataOut[0].
- Latency:
  - DataValid rises on the edge sampling the last bit's BitEn, so it is visible one Clk cycle after that BitEn cycle.
- Handshake:
  - DataAck=1 while DataValid=1 and no completion on that edge: DataValid<=0 on the next edge.
  - DataAck while DataValid=0 has no effect.
  - DataOut holds its value after ack until the next completion.
- Error flags:
  - ClrErr=1 clears FrameErr and Overrun on the next edge.
  - If a set condition and ClrErr occur on the same edge, set wins.
- RxBusy is registered and equals (state != IDLE).

Optional Feature:
- Macro: SERIAL_RX_SYNC_EN.
- When defined:
  - Din and DinValid each pass through a 2-flop synchronizer (reset value 0) before use.
  - Latency from pin to DataValid grows by 2 Clk cycles.
  - The BitEn source must be delayed by 2 cycles to match; BitEn itself is not synchronized.
- When undefined: Din and DinValid are used directly (same-clock source).

Decomposition:
- Package serial_pkg holds:
  - the state enum (IDLE, SHIFT, WAIT_LOW);
  - the default WIDTH constant (32), shared with the transmitter;
  - a clog2 helper for CNT_W.
- Sub-module bit_sync: 2-flop synchronizer, async active-low reset. Instantiated twice, only under SERIAL_RX_SYNC_EN.

Test Plan:
- Nominal frame: send 0xA5C3_0F81 MSB first (32 BitEn strobes, DinValid high) -> DataOut=0xA5C3_0F81, DataValid=1 one cycle after the 32nd BitEn, RxBusy low once DinValid drops.
- Handshake: hold DataAck=0 and send a second word 0x1234_5678 -> Overrun=1, DataOut still 0xA5C3_0F81. Pulse ClrErr -> Overrun=0. Ack, then resend -> DataOut=0x1234_5678.
- Ack on completion edge: DataValid=1 with DataAck=1 on the edge completing 0xDEAD_BEEF -> DataValid stays 1, DataOut=0xDEAD_BEEF, Overrun=0.
- Frame error: drop DinValid after 17 bits -> FrameErr=1, state IDLE, DataValid unchanged. A following full frame 0xFFFF_0000 is received correctly.
- Reset mid-frame: assert Reset=0 after 10 bits -> all outputs 0 immediately (asynchronous). After release, a full frame 0x0000_0001 yields DataOut=0x0000_0001.
- Tail guard plus SERIAL_RX_SYNC_EN build: keep DinValid high 3 extra BitEn periods after 32 bits -> exactly one word and no new frame. With the macro defined, DataValid appears 2 cycles later than in the nominal test.
